// File: rtl/store_result_monitor.sv
// store_result_monitor: on-chip pass/fail/timeout checker for the core store stream with a small debug log of recent stores.
module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int          TIMEOUT      = 1000,
  parameter int          CW           = 16,
  parameter int          LOG_DEPTH    = 4,
  parameter int          LW           = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataaddr,
  input  logic [31:0]   writedata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [15:0]   store_count,
  output logic [CW-1:0] cycle_count,
  output logic [31:0]   dec_addr,
  output logic [31:0]   dec_data,
  input  logic [LW-1:0] rd_idx,
  output logic [31:0]   rd_addr,
  output logic [31:0]   rd_data
);
  typedef enum logic [1:0] {RUN, PASS, FAIL, TOUT} state_t;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [LW:0]   FULL    = (LW+1)'(LOG_DEPTH);
  state_t state, state_n;
  logic run, acc, hit, dec;
  logic [LW-1:0] wr_ptr, ridx;
  logic [LW:0] occ;
  logic [31:0] log_addr [LOG_DEPTH];
  logic [31:0] log_data [LOG_DEPTH];
  assign run  = state == RUN;
  assign acc  = run && memwrite;
  assign hit  = dataaddr == PASS_ADDR && writedata == PASS_DATA;
  assign dec  = acc && (hit || dataaddr != SCRATCH_ADDR);
  assign ridx = wr_ptr - 1'b1 - rd_idx;
  assign done    = state != RUN;
  assign pass    = state == PASS;
  assign fail    = state == FAIL;
  assign timeout = state == TOUT;
  // A store decision on the timeout edge wins over the timeout.
  always_comb begin
    state_n = state;
    if (run) state_n = dec ? (hit ? PASS : FAIL) : (cycle_count == TO_LAST ? TOUT : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      store_count <= '0;
      cycle_count <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      dec_addr    <= '0;
      dec_data    <= '0;
      rd_addr     <= '0;
      rd_data     <= '0;
    end else begin
      state   <= state_n;
      rd_addr <= {1'b0, rd_idx} >= occ ? '0 : log_addr[ridx];
      rd_data <= {1'b0, rd_idx} >= occ ? '0 : log_data[ridx];
      if (run && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;
      if (acc) begin
        if (!(&store_count)) store_count <= store_count + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        if (occ != FULL) occ <= occ + 1'b1;
      end
      if (dec) begin
        dec_addr <= dataaddr;
        dec_data <= writedata;
      end
    end
  end
  // Log storage is left uncleared on reset; occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (acc && !reset) begin
      log_addr[wr_ptr] <= dataaddr;
      log_data[wr_ptr] <= writedata;
    end
  end
endmodule
